// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, halt
// causes and the decode type codes consumed from the id stage.
package core_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_HALT   = 3'd5
    } seq_state_e;

    localparam logic [2:0] HALT_NONE      = 3'd0;
    localparam logic [2:0] HALT_GOOD_TRAP = 3'd1;
    localparam logic [2:0] HALT_BAD_TRAP  = 3'd2;
    localparam logic [2:0] HALT_ILLEGAL   = 3'd3;
    localparam logic [2:0] HALT_BUS_ERR   = 3'd4;
    localparam logic [2:0] HALT_TIMEOUT   = 3'd5;

    localparam logic [3:0] NO_TYPE       = 4'd0;
    localparam logic [3:0] R_TYPE        = 4'd1;
    localparam logic [3:0] I_TYPE_A_TYPE = 4'd2;
    localparam logic [3:0] I_TYPE_L_TYPE = 4'd3;
    localparam logic [3:0] I_TYPE_J_TYPE = 4'd4;
    localparam logic [3:0] I_TYPE_E_TYPE = 4'd5;
    localparam logic [3:0] S_TYPE        = 4'd6;
    localparam logic [3:0] B_TYPE        = 4'd7;
    localparam logic [3:0] U_TYPE        = 4'd8;
    localparam logic [3:0] J_TYPE        = 4'd9;

    function automatic logic [2:0] trap_code(input logic good);
        return good ? HALT_GOOD_TRAP : HALT_BAD_TRAP;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_fetch_timer.sv
// Counts consecutive FETCH cycles; expire is high on the FETCH_TIMEOUT-th cycle
// of a fetch that has not yet been acknowledged.
module seq_fetch_timer
    import core_seq_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds completed FETCH cycles, so cycle N of the fetch sees N-1.
    assign expire = en && (cnt_q == TW'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer; owns every architectural write
// enable and halts on ebreak, illegal instruction, bus error or fetch timeout.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             ir_wen,
    input  logic [3:0]       inst_type,
    input  logic             trap_good,
    input  logic             id_rd_wen,
    input  logic             ex_ready,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic             halted,
    output logic [2:0]       halt_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    seq_state_e       state_q, state_d;
    logic [2:0]       halt_code_q, halt_code_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             tmr_clear, tmr_en, tmr_expire;

    seq_fetch_timer #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        imem_req    = 1'b0;
        ir_wen      = 1'b0;
        rf_wen      = 1'b0;
        pc_wen      = 1'b0;
        tmr_en      = (state_q == SEQ_FETCH);
        tmr_clear   = 1'b1;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) state_d = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                imem_req  = 1'b1;
                tmr_clear = 1'b0;
                // Bus error outranks a same-cycle ack; an ack outranks expiry.
                if (imem_err) begin
                    state_d     = SEQ_HALT;
                    halt_code_d = HALT_BUS_ERR;
                    tmr_clear   = 1'b1;
                end else if (imem_ack) begin
                    ir_wen    = 1'b1;
                    state_d   = SEQ_DECODE;
                    tmr_clear = 1'b1;
                end else if (tmr_expire) begin
                    state_d     = SEQ_HALT;
                    halt_code_d = HALT_TIMEOUT;
                    tmr_clear   = 1'b1;
                end
            end
            SEQ_DECODE: begin
                if (inst_type == NO_TYPE) begin
                    state_d     = SEQ_HALT;
                    halt_code_d = HALT_ILLEGAL;
                end else if (inst_type == I_TYPE_E_TYPE) begin
                    state_d     = SEQ_HALT;
                    halt_code_d = trap_code(trap_good);
                end else begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (ex_ready) state_d = SEQ_WB;
            end
            SEQ_WB: begin
                rf_wen  = id_rd_wen;
                pc_wen  = 1'b1;
                state_d = SEQ_FETCH;
            end
            SEQ_HALT: begin
                state_d = SEQ_HALT;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        cycles_d  = cycles_q;
        retired_d = retired_q;
        if (state_q != SEQ_IDLE && state_q != SEQ_HALT) cycles_d = cycles_q + CNT_W'(1);
        if (state_q == SEQ_WB) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            halt_code_q <= HALT_NONE;
            cycles_q    <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
            cycles_q    <= cycles_d;
            retired_q   <= retired_d;
        end
    end

    assign halted    = (state_q == SEQ_HALT);
    assign halt_code = halt_code_q;
    assign state     = state_q;
    assign cycles    = cycles_q;
    assign retired   = retired_q;

endmodule
